// File: rtl/i2s_pkg.sv
// i2s_pkg: I2S frame geometry and FSM state encoding,
// shared by the encoder RTL and the i2s_decoder benches.
package i2s_pkg;

  localparam int SLOT_BITS   = 32;
  localparam int FRAME_SLOTS = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_t;

endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: SCK divider with one-clock rise/fall strobes.
// Held cleared while the encoder is idle.
module i2s_clkgen #(
  parameter int HALF_DIV = 10
) (
  input  logic clk_60MHz,
  input  logic rst,
  input  logic clr,
  output logic sck,
  output logic sck_rise,
  output logic sck_fall
);

  localparam int CW = $clog2(HALF_DIV);

  logic [CW-1:0] div;
  logic          tick;

  assign tick     = (div == CW'(HALF_DIV - 1));
  assign sck_rise = tick & ~sck;
  assign sck_fall = tick & sck;

  always_ff @(posedge clk_60MHz) begin
    if (rst || clr) begin
      div <= '0;
      sck <= 1'b0;
    end else if (tick) begin
      div <= '0;
      sck <= ~sck;
    end else begin
      div <= div + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_encoder.sv
// i2s_encoder: parallel L/R pairs in, I2S SCK/WS/SD out.
// One-deep holding register; whole 64-slot frames only.
module i2s_encoder
  import i2s_pkg::*;
#(
  parameter int DATAWIDTH = 24,
  parameter int HALF_DIV  = 10
) (
  input  logic                 clk_60MHz,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_left,
  input  logic [DATAWIDTH-1:0] in_right,
  output logic                 sck,
  output logic                 ws,
  output logic                 sd,
  output logic                 frame_start,
  output logic                 underrun,
  output logic                 busy
);

  localparam logic [5:0] LAST_SLOT = 6'(FRAME_SLOTS - 1);
  localparam logic [5:0] LAST_LEFT = 6'(FRAME_SLOTS / 2 - 1);

  i2s_state_t state, state_nxt;

  logic                 load;
  logic                 sck_fall;
  logic                 unused_sck_rise;
  logic [5:0]           slot;
  logic [SLOT_BITS-1:0] shreg;
  logic                 hold_full;
  logic [DATAWIDTH-1:0] hold_l, hold_r;
  logic [DATAWIDTH-1:0] act_r;

  // {1'b0 delay slot, sample MSB..LSB, zero pad}
  function automatic logic [SLOT_BITS-1:0] frame_word(
    input logic [DATAWIDTH-1:0] s
  );
    return SLOT_BITS'(s) << (SLOT_BITS - 1 - DATAWIDTH);
  endfunction

  i2s_clkgen #(
    .HALF_DIV (HALF_DIV)
  ) u_clkgen (
    .clk_60MHz (clk_60MHz),
    .rst       (rst),
    .clr       (state == IDLE),
    .sck       (sck),
    .sck_rise  (unused_sck_rise),
    .sck_fall  (sck_fall)
  );

  assign in_ready = ~hold_full;
  assign busy     = (state == RUN);
  assign sd       = shreg[SLOT_BITS-1];

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_en) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (sck_fall && slot == LAST_SLOT) begin
          if (tx_en) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_60MHz) begin
    if (rst) begin
      state       <= IDLE;
      slot        <= '0;
      shreg       <= '0;
      ws          <= 1'b1;
      hold_full   <= 1'b0;
      hold_l      <= '0;
      hold_r      <= '0;
      act_r       <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_start <= load;
      underrun    <= load & ~hold_full;

      if (in_valid && !hold_full) begin
        hold_full <= 1'b1;
        hold_l    <= in_left;
        hold_r    <= in_right;
      end

      if (load) begin
        slot  <= '0;
        ws    <= 1'b0;
        shreg <= frame_word(hold_full ? hold_l : '0);
        act_r <= hold_full ? hold_r : '0;
        if (hold_full) begin
          hold_full <= 1'b0;
        end
      end else if (state == RUN && state_nxt == IDLE) begin
        slot  <= '0;
        ws    <= 1'b1;
        shreg <= '0;
      end else if (state == RUN && sck_fall) begin
        slot <= slot + 6'd1;
        if (slot == LAST_LEFT) begin
          ws    <= 1'b1;
          shreg <= frame_word(act_r);
        end else begin
          shreg <= shreg << 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_encoder.sv
// tb_i2s_encoder: scoreboard bench; frames are rebuilt from
// sck rises and compared with pairs queued at acceptance.
module tb_i2s_encoder;

  localparam int DW  = 24;
  localparam int HD  = 2;
  localparam int LIM = 4000;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          tx_en    = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_left  = '0;
  logic [DW-1:0] in_right = '0;
  logic          in_ready, sck, ws, sd;
  logic          frame_start, underrun, busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  i2s_encoder #(
    .DATAWIDTH (DW),
    .HALF_DIV  (HD)
  ) dut (
    .clk_60MHz   (clk),
    .rst         (rst),
    .tx_en       (tx_en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_left     (in_left),
    .in_right    (in_right),
    .sck         (sck),
    .ws          (ws),
    .sd          (sd),
    .frame_start (frame_start),
    .underrun    (underrun),
    .busy        (busy)
  );

  always #8 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]   edg;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  pair_t exp_q[$];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL timeout %s at cycle %0d", name, cyc);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [63:0]   got_sd = '0, got_ws = '0;
  logic [DW-1:0] cur_l = '0, cur_r = '0;
  int            nrise = 0, fs_edge = 0, n_under = 0;
  bit            active = 0, exp_ur = 0;
  logic          prev_sck = 0, prev_busy = 0, prev_fs = 0;
  pair_t         pp;

  task automatic finalize();
    check("rises", 64'(nrise), 64'd64);
    check("sd_frame", got_sd,
          {1'b0, cur_l, {(31-DW){1'b0}},
           1'b0, cur_r, {(31-DW){1'b0}}});
    check("ws_frame", got_ws, {32'h0, 32'hffff_ffff});
  endtask

  always @(negedge clk) begin
    if (rst) begin
      active = 0;
      nrise  = 0;
      exp_q.delete();
    end else begin
      if (sck && !prev_sck && active) begin
        if (nrise == 0)
          check("first_rise", 64'(cyc - fs_edge), 64'(HD));
        if (nrise < 64) begin
          got_sd[63-nrise] = sd;
          got_ws[63-nrise] = ws;
        end
        nrise++;
      end
      if (underrun) begin
        n_under++;
        check("ur_with_fs", 64'(frame_start), 64'd1);
      end
      if (frame_start) begin
        check("fs_one_cycle", 64'(prev_fs), 64'd0);
        if (active) begin
          finalize();
          check("period", 64'(cyc - fs_edge), 64'(128 * HD));
        end
        exp_ur = 1;
        cur_l  = '0;
        cur_r  = '0;
        if (exp_q.size() > 0 && int'(exp_q[0].edg) < cyc) begin
          pp     = exp_q.pop_front();
          cur_l  = pp.l;
          cur_r  = pp.r;
          exp_ur = 0;
        end
        check("underrun_flag", 64'(underrun), 64'(exp_ur));
        active  = 1;
        fs_edge = cyc;
        nrise   = 0;
        got_sd  = '0;
        got_ws  = '0;
      end else if (prev_busy && !busy && active) begin
        finalize();
        active = 0;
        check("stop_ws", 64'(ws), 64'd1);
        check("stop_sck", 64'(sck), 64'd0);
      end
    end
    prev_sck  = sck;
    prev_busy = busy;
    prev_fs   = frame_start;
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [DW-1:0] l,
                      input logic [DW-1:0] r,
                      output int acc);
    bit done;
    done     = 0;
    acc      = -1;
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    for (int t = 0; t < LIM && !done; t++) begin
      if (in_ready) begin
        pp.edg = 32'(cyc + 1);
        pp.l   = l;
        pp.r   = r;
        exp_q.push_back(pp);
        acc  = cyc + 1;
        done = 1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) timeout("send");
    else check("ready_low", 64'(in_ready), 64'd0);
  endtask

  task automatic wait_frames(input int n);
    int seen;
    seen = 0;
    for (int t = 0; t < LIM * n && seen < n; t++) begin
      @(negedge clk);
      if (frame_start) seen++;
    end
    if (seen < n) timeout("frames");
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int t = 0; t < LIM && !ok; t++) begin
      @(negedge clk);
      ok = !busy;
    end
    if (!ok) timeout("idle");
  endtask

  task automatic wait_slot(input int s);
    bit ok;
    ok = 0;
    for (int t = 0; t < LIM && !ok; t++) begin
      @(negedge clk);
      ok = (nrise >= s);
    end
    if (!ok) timeout("slot");
  endtask

  task automatic check_reset();
    check("rst_sck", 64'(sck), 64'd0);
    check("rst_ws", 64'(ws), 64'd1);
    check("rst_sd", 64'(sd), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_fs", 64'(frame_start), 64'd0);
    check("rst_ur", 64'(underrun), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int a;
    int ur0;
    logic [DW-1:0] l, r;

    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;
    @(negedge clk);

    // basic frame, then stop requested at slot 10
    send(24'hA5A5A5, 24'h3C3C3C, a);
    tx_en = 1'b1;
    wait_frames(1);
    wait_slot(10);
    tx_en = 1'b0;
    wait_idle();
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_ws", 64'(ws), 64'd1);
    check("idle_sck", 64'(sck), 64'd0);

    // extreme left value, random right
    send(24'h800001, DW'($urandom), a);
    tx_en = 1'b1;
    wait_frames(1);
    tx_en = 1'b0;
    wait_idle();

    // three underrun frames
    ur0   = n_under;
    tx_en = 1'b1;
    wait_frames(3);
    tx_en = 1'b0;
    wait_idle();
    @(negedge clk);
    check("underrun_count", 64'(n_under - ur0), 64'd3);

    // backpressure with in_valid held
    tx_en = 1'b1;
    send(DW'($urandom), DW'($urandom), a);
    send(DW'($urandom), DW'($urandom), a);
    check("p2_accept_edge", 64'(a), 64'(fs_edge + 1));
    send(DW'($urandom), DW'($urandom), a);
    check("p3_accept_edge", 64'(a), 64'(fs_edge + 1));
    for (int i = 0; i < 4; i++) begin
      l = DW'($urandom);
      r = DW'($urandom);
      repeat ($urandom_range(0, 300)) @(negedge clk);
      send(l, r, a);
    end
    for (int t = 0; t < LIM && exp_q.size() > 0; t++)
      @(negedge clk);
    if (exp_q.size() > 0) timeout("drain");
    tx_en = 1'b0;
    wait_idle();

    // reset mid-frame with the holding register full
    send(DW'($urandom), DW'($urandom), a);
    tx_en = 1'b1;
    wait_frames(1);
    send(DW'($urandom), DW'($urandom), a);
    wait_slot(40);
    check("hold_full", 64'(in_ready), 64'd0);
    rst   = 1'b1;
    tx_en = 1'b0;
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'd0);
    ur0   = n_under;
    tx_en = 1'b1;
    wait_frames(1);
    @(negedge clk);
    check("fresh_underrun", 64'(n_under - ur0), 64'd1);
    tx_en = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
